// File: rtl/wb_arbiter_if.sv
// Writeback bus between three functional units and the register-file write port.
// slave = arbiter view, master = producer/consumer view.
interface wb_arbiter_if;
    logic [2:0]  fu_wb_valid;
    logic [2:0]  fu_wb_ready;
    logic [2:0]  fu_wb_writereg;
    logic [14:0] fu_wb_regdest;
    logic [95:0] fu_wb_value;
    logic        wb_reg_en;
    logic [4:0]  wb_reg_addr;
    logic [31:0] wb_reg_data;
    logic [1:0]  arb_grant;
    logic        arb_idle;

    modport slave (
        input  fu_wb_valid, fu_wb_writereg, fu_wb_regdest, fu_wb_value,
        output fu_wb_ready, wb_reg_en, wb_reg_addr, wb_reg_data, arb_grant, arb_idle
    );

    modport master (
        output fu_wb_valid, fu_wb_writereg, fu_wb_regdest, fu_wb_value,
        input  fu_wb_ready, wb_reg_en, wb_reg_addr, wb_reg_data, arb_grant, arb_idle
    );
endinterface

// File: rtl/wb_arbiter.sv
// Per-FU writeback queues arbitrated onto a single register-file write port.
// Define WB_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed FU0 > FU1 > FU2.

module wb_fu_fifo #(
    parameter int DEPTH = 2,
    parameter int EW    = 38
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [EW-1:0] wdata,
    input  logic          pop,
    output logic          ready,
    output logic          nonempty,
    output logic [EW-1:0] rdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;

    // Caller qualifies push with ready and pop with nonempty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign ready    = (count_q < CW'(DEPTH));
    assign nonempty = (count_q != '0);
    assign rdata    = mem_q[rd_ptr_q];
endmodule

module wb_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    wb_arbiter_if.slave bus
);
    localparam int NFU = 3;
    localparam int EW  = 38;

    logic [NFU-1:0]         fifo_ready, fifo_nonempty, push, pop;
    logic [NFU-1:0][EW-1:0] wdata, head;
    logic                   pop_vld;
    logic [1:0]             pop_idx;
    logic [EW-1:0]          sel;

    logic        wb_reg_en_q, wb_reg_en_d;
    logic [4:0]  wb_reg_addr_q, wb_reg_addr_d;
    logic [31:0] wb_reg_data_q, wb_reg_data_d;
    logic [1:0]  arb_grant_q, arb_grant_d;

    // Ready comes only from registered counts, so valid never loops back to ready.
    assign push = bus.fu_wb_valid & fifo_ready;

    for (genvar gi = 0; gi < NFU; gi++) begin : g_fu
        assign wdata[gi] = {bus.fu_wb_writereg[gi],
                            bus.fu_wb_regdest[5*gi +: 5],
                            bus.fu_wb_value[32*gi +: 32]};

        wb_fu_fifo #(
            .DEPTH (FIFO_DEPTH),
            .EW    (EW)
        ) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .push     (push[gi]),
            .wdata    (wdata[gi]),
            .pop      (pop[gi]),
            .ready    (fifo_ready[gi]),
            .nonempty (fifo_nonempty[gi]),
            .rdata    (head[gi])
        );
    end

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [2:0] cand;

    always_comb begin
        pop_vld = 1'b0;
        pop_idx = 2'd0;
        cand    = 3'd0;
        for (int k = 0; k < NFU; k++) begin
            cand = {1'b0, rr_ptr_q} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!pop_vld && fifo_nonempty[cand[1:0]]) begin
                pop_vld = 1'b1;
                pop_idx = cand[1:0];
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (pop_vld) begin
            rr_ptr_d = (pop_idx == 2'd2) ? 2'd0 : pop_idx + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        pop_vld = 1'b0;
        pop_idx = 2'd0;
        for (int k = 0; k < NFU; k++) begin
            if (!pop_vld && fifo_nonempty[k]) begin
                pop_vld = 1'b1;
                pop_idx = 2'(k);
            end
        end
    end
`endif

    // Address/data follow every pop, even ones that do not write.
    always_comb begin
        pop           = '0;
        sel           = '0;
        wb_reg_en_d   = 1'b0;
        wb_reg_addr_d = wb_reg_addr_q;
        wb_reg_data_d = wb_reg_data_q;
        arb_grant_d   = 2'b11;
        if (pop_vld) begin
            pop[pop_idx]  = 1'b1;
            sel           = head[pop_idx];
            wb_reg_en_d   = sel[37] & (sel[36:32] != 5'd0);
            wb_reg_addr_d = sel[36:32];
            wb_reg_data_d = sel[31:0];
            arb_grant_d   = pop_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_reg_en_q   <= 1'b0;
            wb_reg_addr_q <= 5'd0;
            wb_reg_data_q <= 32'd0;
            arb_grant_q   <= 2'b11;
        end else begin
            wb_reg_en_q   <= wb_reg_en_d;
            wb_reg_addr_q <= wb_reg_addr_d;
            wb_reg_data_q <= wb_reg_data_d;
            arb_grant_q   <= arb_grant_d;
        end
    end

    assign bus.fu_wb_ready = fifo_ready;
    assign bus.wb_reg_en   = wb_reg_en_q;
    assign bus.wb_reg_addr = wb_reg_addr_q;
    assign bus.wb_reg_data = wb_reg_data_q;
    assign bus.arb_grant   = arb_grant_q;
    assign bus.arb_idle    = ~(|fifo_nonempty) & ~wb_reg_en_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_wb_arbiter;
    localparam int DEPTH = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    wb_arbiter_if bus();

    wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one queue of {writereg, regdest, value} per FU.
    logic [37:0] mq [3][$];
    logic        exp_en    = 1'b0;
    logic [4:0]  exp_addr  = 5'd0;
    logic [31:0] exp_data  = 32'd0;
    logic [1:0]  exp_grant = 2'b11;
    int          rr        = 0;

    function automatic logic [37:0] mk(logic wr, logic [4:0] rd, logic [31:0] v);
        return {wr, rd, v};
    endfunction

    function automatic logic [2:0] exp_ready();
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    function automatic logic [40:0] exp_out();
        logic idle;
        idle = (mq[0].size() == 0) && (mq[1].size() == 0) && (mq[2].size() == 0) && !exp_en;
        return {exp_en, exp_addr, exp_data, exp_grant, idle};
    endfunction

    function automatic logic [40:0] got_out();
        return {bus.wb_reg_en, bus.wb_reg_addr, bus.wb_reg_data, bus.arb_grant, bus.arb_idle};
    endfunction

    task automatic drive(int i, logic v, logic [37:0] e);
        bus.fu_wb_valid[i]          = v;
        bus.fu_wb_writereg[i]       = e[37];
        bus.fu_wb_regdest[5*i +: 5] = e[36:32];
        bus.fu_wb_value[32*i +: 32] = e[31:0];
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 38'd0);
    endtask

    // Advance one clock and update the model with what the inputs asked for.
    task automatic tick();
        logic [2:0]  rdy, vld;
        logic [37:0] ent [3];
        logic [37:0] e;
        int          pick;
        rdy = exp_ready();
        vld = bus.fu_wb_valid;
        for (int i = 0; i < 3; i++)
            ent[i] = {bus.fu_wb_writereg[i], bus.fu_wb_regdest[5*i +: 5], bus.fu_wb_value[32*i +: 32]};
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            rr = 0; exp_en = 1'b0; exp_addr = 5'd0; exp_data = 32'd0; exp_grant = 2'b11;
        end else begin
            pick = -1;
`ifdef WB_ARB_ROUND_ROBIN_EN
            for (int k = 0; k < 3; k++)
                if (pick < 0 && mq[(rr + k) % 3].size() > 0) pick = (rr + k) % 3;
            if (pick >= 0) rr = (pick + 1) % 3;
`else
            for (int k = 0; k < 3; k++)
                if (pick < 0 && mq[k].size() > 0) pick = k;
`endif
            if (pick >= 0) begin
                e         = mq[pick].pop_front();
                exp_en    = e[37] && (e[36:32] != 5'd0);
                exp_addr  = e[36:32];
                exp_data  = e[31:0];
                exp_grant = 2'(pick);
            end else begin
                exp_en    = 1'b0;
                exp_grant = 2'b11;
            end
            for (int i = 0; i < 3; i++)
                if (vld[i] && rdy[i]) mq[i].push_back(ent[i]);
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if (got_out() !== {1'b0, 5'd0, 32'd0, 2'b11, 1'b1}) begin
            n_err++;
            $display("FAIL reset_out: got %h expected %h", got_out(), {1'b0, 5'd0, 32'd0, 2'b11, 1'b1});
        end
        n_cmp++;
        if (bus.fu_wb_ready !== 3'b111) begin
            n_err++;
            $display("FAIL reset_ready: got %b expected 111", bus.fu_wb_ready);
        end
    endtask

    task automatic test_single();
        drive(1, 1'b1, mk(1'b1, 5'd5, 32'hDEADBEEF));
        tick();
        idle_inputs();
        n_cmp++;
        if ({bus.wb_reg_en, bus.arb_grant, bus.arb_idle} !== {1'b0, 2'b11, 1'b0}) begin
            n_err++;
            $display("FAIL single_k: got en=%b grant=%b idle=%b expected en=0 grant=11 idle=0",
                     bus.wb_reg_en, bus.arb_grant, bus.arb_idle);
        end
        tick();
        n_cmp++;
        if ({bus.wb_reg_en, bus.wb_reg_addr, bus.wb_reg_data, bus.arb_grant} !==
            {1'b1, 5'd5, 32'hDEADBEEF, 2'd1}) begin
            n_err++;
            $display("FAIL single_k1: got en=%b addr=%0d data=%h grant=%0d expected en=1 addr=5 data=deadbeef grant=1",
                     bus.wb_reg_en, bus.wb_reg_addr, bus.wb_reg_data, bus.arb_grant);
        end
        tick();
        n_cmp++;
        if ({bus.arb_idle, bus.wb_reg_en, bus.arb_grant} !== {1'b1, 1'b0, 2'b11}) begin
            n_err++;
            $display("FAIL single_idle: got idle=%b en=%b grant=%b expected idle=1 en=0 grant=11",
                     bus.arb_idle, bus.wb_reg_en, bus.arb_grant);
        end
    endtask

    // Two rounds: the second starting at FU0 again shows the rotation came back to 0.
    task automatic test_simultaneous();
        logic [31:0] v [3];
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                v[i] = $urandom;
                drive(i, 1'b1, mk(1'b1, 5'(i + 1 + 8*r), v[i]));
            end
            tick();
            idle_inputs();
            for (int c = 0; c < 3; c++) begin
                tick();
                n_cmp++;
                if ({bus.arb_grant, bus.wb_reg_data, bus.wb_reg_en} !== {2'(c), v[c], 1'b1}) begin
                    n_err++;
                    $display("FAIL simul_order r%0d c%0d: got grant=%0d data=%h en=%b expected grant=%0d data=%h en=1",
                             r, c, bus.arb_grant, bus.wb_reg_data, bus.wb_reg_en, c, v[c]);
                end
            end
            tick();
        end
    endtask

    task automatic test_starve();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 3; i++) drive(i, 1'b1, mk(1'b1, 5'($urandom_range(1, 31)), $urandom));
            n_cmp++;
            if (bus.fu_wb_ready !== exp_ready()) begin
                n_err++;
                $display("FAIL starve_ready c%0d: got %b expected %b", c, bus.fu_wb_ready, exp_ready());
            end
            tick();
            n_cmp++;
            if (got_out() !== exp_out()) begin
                n_err++;
                $display("FAIL starve_out c%0d: got %h expected %h", c, got_out(), exp_out());
            end
        end
`ifndef WB_ARB_ROUND_ROBIN_EN
        n_cmp++;
        if ({bus.fu_wb_ready[2:1], bus.arb_grant} !== {2'b00, 2'd0}) begin
            n_err++;
            $display("FAIL starve_fixed: got ready21=%b grant=%0d expected ready21=00 grant=0",
                     bus.fu_wb_ready[2:1], bus.arb_grant);
        end
`endif
        idle_inputs();
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if (got_out() !== exp_out()) begin
                n_err++;
                $display("FAIL starve_drain c%0d: got %h expected %h", c, got_out(), exp_out());
            end
        end
    endtask

    task automatic test_nowrite();
        drive(2, 1'b1, mk(1'b1, 5'd0, $urandom));
        tick();
        drive(2, 1'b1, mk(1'b0, 5'd7, $urandom));
        tick();
        idle_inputs();
        n_cmp++;
        if ({bus.wb_reg_en, bus.arb_grant} !== {1'b0, 2'd2}) begin
            n_err++;
            $display("FAIL nowrite_1: got en=%b grant=%0d expected en=0 grant=2", bus.wb_reg_en, bus.arb_grant);
        end
        tick();
        n_cmp++;
        if ({bus.wb_reg_en, bus.arb_grant, bus.wb_reg_addr} !== {1'b0, 2'd2, 5'd7}) begin
            n_err++;
            $display("FAIL nowrite_2: got en=%b grant=%0d addr=%0d expected en=0 grant=2 addr=7",
                     bus.wb_reg_en, bus.arb_grant, bus.wb_reg_addr);
        end
        n_cmp++;
        if (got_out() !== exp_out()) begin
            n_err++;
            $display("FAIL nowrite_model: got %h expected %h", got_out(), exp_out());
        end
        tick();
        n_cmp++;
        if ({bus.arb_idle, bus.arb_grant} !== {1'b1, 2'b11}) begin
            n_err++;
            $display("FAIL nowrite_idle: got idle=%b grant=%b expected idle=1 grant=11", bus.arb_idle, bus.arb_grant);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 3; i++) drive(i, 1'b1, mk(1'b1, 5'($urandom_range(1, 31)), $urandom));
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        n_cmp++;
        if ({bus.fu_wb_ready, got_out()} !== {3'b111, 1'b0, 5'd0, 32'd0, 2'b11, 1'b1}) begin
            n_err++;
            $display("FAIL reset_mid: got ready=%b out=%h expected ready=111 out=%h",
                     bus.fu_wb_ready, got_out(), {1'b0, 5'd0, 32'd0, 2'b11, 1'b1});
        end
        tick();
        n_cmp++;
        if ({bus.wb_reg_en, bus.arb_grant, bus.arb_idle} !== {1'b0, 2'b11, 1'b1}) begin
            n_err++;
            $display("FAIL reset_mid_after: got en=%b grant=%b idle=%b expected en=0 grant=11 idle=1",
                     bus.wb_reg_en, bus.arb_grant, bus.arb_idle);
        end
    endtask

    task automatic test_stream();
        logic [31:0] sent [$];
        logic [31:0] got [$];
        logic [31:0] v;
        for (int n = 0; n < 10; n++) begin
            v = $urandom;
            sent.push_back(v);
            drive(1, 1'b1, mk(1'b1, 5'($urandom_range(1, 31)), v));
            n_cmp++;
            if (bus.fu_wb_ready[1] !== 1'b1) begin
                n_err++;
                $display("FAIL stream_ready n%0d: got %b expected 1", n, bus.fu_wb_ready[1]);
            end
            tick();
            if (bus.arb_grant == 2'd1) got.push_back(bus.wb_reg_data);
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.arb_grant == 2'd1) got.push_back(bus.wb_reg_data);
        end
        n_cmp++;
        if (got.size() != 10) begin
            n_err++;
            $display("FAIL stream_count: got %0d expected 10", got.size());
        end
        for (int j = 0; j < 10 && j < got.size(); j++) begin
            n_cmp++;
            if (got[j] !== sent[j]) begin
                n_err++;
                $display("FAIL stream_val j%0d: got %h expected %h", j, got[j], sent[j]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++)
                drive(i, ($urandom_range(0, 2) != 0),
                      mk(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom));
            reset = ($urandom_range(0, 99) == 0);
            n_cmp++;
            if (bus.fu_wb_ready !== exp_ready()) begin
                n_err++;
                $display("FAIL rand_ready c%0d: got %b expected %b", c, bus.fu_wb_ready, exp_ready());
            end
            tick();
            n_cmp++;
            if (got_out() !== exp_out()) begin
                n_err++;
                $display("FAIL rand_out c%0d: got %h expected %h", c, got_out(), exp_out());
            end
        end
        reset = 1'b0;
        idle_inputs();
        for (int c = 0; c < 10; c++) tick();
        n_cmp++;
        if (got_out() !== exp_out() || bus.arb_idle !== 1'b1) begin
            n_err++;
            $display("FAIL rand_drain: got %h expected %h", got_out(), exp_out());
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_simultaneous();
        test_starve();
        test_nowrite();
        test_reset_mid();
        test_stream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, per-unit writeback queue depth; power of two, >= 2.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 fu_wb_valid  input  3  per functional unit (bit i = FU i): writeback request valid.
REQ-005 fu_wb_ready  output  3  per FU: queue can accept this cycle.
REQ-006 fu_wb_writereg  input  3  per FU: result is to be written to the register file.
REQ-007 fu_wb_regdest  input  15  per FU: destination register, FU i in bits [5i+4:5i].
REQ-008 fu_wb_value  input  96  per FU: result data, FU i in bits [32i+31:32i].
REQ-009 wb_reg_en  output  1  register-file write enable.
REQ-010 wb_reg_addr  output  5  register-file write address.
REQ-011 wb_reg_data  output  32  register-file write data.
REQ-012 arb_grant  output  2  index of FU popped at last edge; 2'b11 = none.
REQ-013 arb_idle  output  1  all queues empty and no write pending on wb_reg_*.

Function
REQ-014 Each FU SHALL own a FIFO of FIFO_DEPTH entries {writereg, regdest, value}.
REQ-015 fu_wb_ready[i] SHALL equal (count_i < FIFO_DEPTH), registered state only; no combinational path from any fu_wb_valid.
REQ-016 Push on FU i SHALL occur at an edge where fu_wb_valid[i] & fu_wb_ready[i]; valid with ready low SHALL be ignored (FU holds).
REQ-017 Full queue SHALL not accept a push even if it pops the same cycle.
REQ-018 Each cycle the arbiter SHALL pick at most one non-empty FIFO head and pop it at the edge.
REQ-019 Push and pop on the same FIFO in the same cycle SHALL both take effect, count unchanged.
REQ-020 Popped entry SHALL be registered into wb_reg_* at the same edge; wb_reg_en = writereg & (regdest != 0).
REQ-021 Cycles with no pop SHALL drive wb_reg_en = 0; wb_reg_addr/data hold previous values.
REQ-022 Latency: entry pushed at edge k into an empty system SHALL appear on wb_reg_* after edge k+1; throughput one writeback per cycle.
REQ-023 Entries with writereg = 0 or regdest = 0 SHALL still be queued and popped in order, producing no write.
REQ-024 Per-FU order SHALL be preserved; no ordering guarantee between FUs.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH without losing entries.
REQ-026 arb_grant SHALL be registered: popped index after the edge, 2'b11 when no pop.
REQ-027 arb_idle SHALL be 1 iff all counts are 0 and wb_reg_en is 0.

Reset
REQ-028 At a reset edge all FIFOs SHALL empty, pointers and round-robin pointer go to 0, wb_reg_en/addr/data = 0, arb_grant = 2'b11; pushes/pops that cycle are discarded.
REQ-029 After reset: fu_wb_ready = 3'b111, arb_idle = 1; reset mid-traffic SHALL drop all queued entries with no write issued.

Configuration
REQ-030 Macro WB_ARB_ROUND_ROBIN_EN defined: priority SHALL start at rr_ptr (reset 0) and rotate; after granting FU i, rr_ptr = (i+1) mod 3; no grant leaves rr_ptr unchanged.
REQ-031 Macro WB_ARB_ROUND_ROBIN_EN undefined: fixed priority FU0 > FU1 > FU2; no rr_ptr state.

Verification
REQ-032 Single push FU1 {writereg=1, regdest=5, value=0xDEADBEEF} at edge k -> wb_reg_en=1, addr=5, data=0xDEADBEEF after edge k+1, arb_grant=1, then arb_idle=1.
REQ-033 All three FUs push simultaneously, round-robin enabled -> writebacks in order FU0, FU1, FU2 on three consecutive cycles; rr_ptr ends at 0.
REQ-034 Same as REQ-033 with FU0 pushing continuously, macro undefined -> FU0 wins every cycle; FU1/FU2 stall, fu_wb_ready[2:1] drop to 0 once full (FIFO_DEPTH=2).
REQ-035 FU2 pushes {writereg=1, regdest=0} then {writereg=0, regdest=7} -> two pops, arb_grant=2 both cycles, wb_reg_en stays 0.
REQ-036 Fill FU0 FIFO (2 entries), assert reset for one edge while valid held -> next cycle fu_wb_ready=3'b111, wb_reg_en=0, arb_grant=2'b11, arb_idle=1.
REQ-037 Stream 10 entries through FU1 with wb_arbiter popping each cycle -> values emerge in push order across pointer wrap, none lost or duplicated.
